// File: rtl/mito_pkg.sv
// mito_pkg: shared widths, mode encodings and pooling-stage state type.
package mito_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_WIDTH = 32;
  localparam int DIM_BITS = 6;
  typedef enum logic [1:0] {CONVOL, FULLY, POOL} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} pool_state_t;
endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: one-write one-read array holding horizontal pair maxima of an even row.
module pool_line_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]                rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2 stride-2 signed max pooling over a raster-ordered feature map.
module max_pool_stream #(
  parameter int DATA_WIDTH = mito_pkg::DATA_WIDTH,
  parameter int MAX_WIDTH = mito_pkg::MAX_WIDTH,
  parameter int DIM_BITS = mito_pkg::DIM_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DIM_BITS-1:0]          cfg_width,
  input  logic [DIM_BITS-1:0]          cfg_height,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         cfg_err
);
  import mito_pkg::*;
  localparam int AW = $clog2(MAX_WIDTH / 2);
  pool_state_t state, state_d;
  logic [DIM_BITS-1:0] w, h, col, row;
  logic signed [DATA_WIDTH-1:0] hold, m, lb_rd, pool;
  logic accept, col_last, last_beat, drain, cfg_ok, launch;
  assign cfg_ok = cfg_width != '0 && !cfg_width[0] && int'(cfg_width) <= MAX_WIDTH &&
                  !cfg_height[0] && cfg_height >= DIM_BITS'(2);
  assign launch = state == IDLE && start && cfg_ok;
  assign in_ready = state == RUN && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign col_last = col == w - 1'b1;
  assign last_beat = col_last && row == h - 1'b1;
  assign drain = !out_valid || out_ready;
  assign m = (hold > in_data) ? hold : in_data;
  assign pool = (lb_rd > m) ? lb_rd : m;
  assign busy = state != IDLE;
  pool_line_buf #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH / 2), .AW(AW)) u_lb (
    .clk(clk),
    .wr_en(accept && col[0] && !row[0]),
    .wr_addr(AW'(col >> 1)),
    .wr_data(m),
    .rd_addr(AW'(col >> 1)),
    .rd_data(lb_rd)
  );
  always_comb begin
    state_d = state;
    state_d = launch ? RUN :
              (state == RUN && accept && last_beat) ? FLUSH :
              (state == FLUSH && drain) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w <= '0;
      h <= '0;
      col <= '0;
      row <= '0;
      hold <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      frame_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      frame_done <= state == FLUSH && drain;
      cfg_err <= state == IDLE && start && !cfg_ok;
      if (launch) begin
        w <= cfg_width;
        h <= cfg_height;
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col <= col_last ? '0 : col + 1'b1;
        row <= col_last ? row + 1'b1 : row;
        if (!col[0]) hold <= in_data;
      end
      // A freshly completed window takes priority over retiring the held result.
      if (accept && col[0] && row[0]) begin
        out_valid <= 1'b1;
        out_data <= pool;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage.
- Sits directly downstream of the ReLU stage and upstream of the OFM buffer, selected when mode is POOL.
- Consumes ReLU outputs in raster order (row-major, one element per beat) and emits one pooled element per 2x2 window.
- Uses a half-width line buffer and valid/ready handshakes on both sides.

Parameters:
- DATA_WIDTH, 8, signed element width (matches ofm_output_width).
- MAX_WIDTH, 32, maximum feature-map width in elements; must be even.
- DIM_BITS, 6, width of the cfg_width and cfg_height fields.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  one-cycle pulse; latches cfg and begins a frame.
- cfg_width  in  DIM_BITS  feature-map width W; must be even, 2..MAX_WIDTH.
- cfg_height  in  DIM_BITS  feature-map height H; must be even and >=2.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage accepts input.
- in_data  in  DATA_WIDTH  signed ReLU output element.
- out_valid  out  1  pooled element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  signed pooled max.
- busy  out  1  frame in progress (RUN or FLUSH).
- frame_done  out  1  one-cycle pulse when the last pooled element has been taken.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, cfg_err=0; state=IDLE; counters=0. Line-buffer contents are not reset; every entry is written before it is read.
- States:
  - IDLE: start with valid cfg -> latch W and H, clear col and row, go to RUN. start with invalid cfg (odd, zero, W>MAX_WIDTH, H<2) -> cfg_err=1 next cycle, stay in IDLE.
  - RUN: accept beats.
  - FLUSH: entered after the last beat (row=H-1, col=W-1) is accepted.
  - FLUSH exit: when out_valid=0, or out_valid&&out_ready -> frame_done pulse, go to IDLE.
- start in RUN or FLUSH is ignored; no cfg_err is raised.
- in_ready = (state==RUN) && (!out_valid || out_ready). It is combinational from the state and output register only, with no dependence on in_valid.
- Beat accepted when in_valid && in_ready:
  - col even: hold_reg <= in_data.
  - col odd: m = signed max(hold_reg, in_data).
  - row even: lb[col>>1] <= m.
  - row odd: out_data <= signed max(lb[col>>1], m); out_valid <= 1 on the next edge.
- Counters: col wraps W-1 -> 0 and increments row. row is not wrapped; the frame ends at H-1.
- Output register:
  - out_valid clears on out_valid && out_ready unless a new result loads in the same cycle; a new load wins.
  - out_data holds its value while out_valid && !out_ready.
- Latency: the pooled result is visible one cycle after the beat completing the window (odd row, odd col) is accepted.
- Throughput: one beat per cycle with no backpressure. Output count per frame = (W/2)*(H/2).
- Arithmetic: two's-complement signed compares; ties return the same value. No width growth; out_data has DATA_WIDTH bits.
- Line buffer:
  - Read at address col>>1 in the same cycle as the write/compare. Read is combinational, or registered with the read address issued on the even-col beat; the implementation picks one, and the timing above must hold.
  - Read and write on the same address never collide within one beat.
- Asynchronous reset mid-frame: return to IDLE immediately. Any pending out_valid is dropped and no frame_done is issued.

Decomposition:
- Shared package mito_pkg: DATA_WIDTH, MAX_WIDTH, DIM_BITS constants; mode encodings CONVOL/FULLY/POOL; pool state enum {IDLE, RUN, FLUSH}.
- Sub-module pool_line_buf: simple dual-port array of MAX_WIDTH/2 x DATA_WIDTH, one write port and one read port, no reset.

Test Plan:
- 4x4 frame, W=H=4, rows {1,5,2,0},{3,4,9,8},{7,6,0,1},{2,8,3,3}, out_ready=1 -> outputs 5, 9, 8, 3 in order; frame_done one cycle after the last output; in_ready high every RUN cycle.
- Signed values, 2x2 frame {-3,-7},{-1,-128} -> single output -1; busy falls after frame_done.
- Backpressure, same 4x4 frame, out_ready low for 5 cycles after the first output -> out_data holds 5 and in_ready=0 while stalled; no beats lost; the output sequence is unchanged.
- Bad configuration: start with W=3 or H=0 -> cfg_err pulse, busy stays 0, in_ready stays 0.
- Reset mid-frame: rst_n asserted after 6 beats of a 4x4 frame, then a new 2x2 frame {4,2},{1,0} -> output 4 only; no stale output appears.
- Start pulse during RUN -> ignored; current frame completes with its original W and H.
